ctrl_pipe_unit: RTL and testbench

- Pipelined successor of the combinational opcode-to-control decoder.
- Decodes the ID-stage opcode into the 13-bit control word and carries it, with the destination register, through EX, MEM and WB stage registers.
- Detects load-use hazards: stalls IF/ID and injects a bubble.
- Handles EX-resolved branch/jump redirects: flushes ID and EX.
- Sits between the IF/ID latch and the datapath stage registers.

---
 rtl/ctrl_pkg.sv | 95 +++++++++
 rtl/ctrl_decode.sv | 37 +++
 rtl/ctrl_pipe_unit.sv | 147 ++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Opcodes, control-word layout and the opcode decode table.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam int CTRL_W = 13;
    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef struct packed {
        logic  illegal;
        ctrl_t ctrl;
    } dec_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_MIN  = 4'b0001;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    localparam int CB_ALUOP_LSB = 10;
    localparam int CB_USEIMM    = 9;
    localparam int CB_MEMREAD   = 8;
    localparam int CB_MEMWRITE  = 7;
    localparam int CB_REGWRITE  = 6;
    localparam int CB_MEMTOREG  = 5;
    localparam int CB_PCTOREG   = 4;
    localparam int CB_BRZ       = 3;
    localparam int CB_BRN       = 2;
    localparam int CB_JUMP      = 1;
    localparam int CB_JUMPMEM   = 0;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_INC   = 3'b001;
    localparam logic [2:0] ALU_NOP   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b101;
    localparam logic [2:0] ALU_NEG   = 3'b110;
    localparam logic [2:0] ALU_PASSA = 3'b111;

    localparam ctrl_t M_USEIMM   = ctrl_t'(1) << CB_USEIMM;
    localparam ctrl_t M_MEMREAD  = ctrl_t'(1) << CB_MEMREAD;
    localparam ctrl_t M_MEMWRITE = ctrl_t'(1) << CB_MEMWRITE;
    localparam ctrl_t M_REGWRITE = ctrl_t'(1) << CB_REGWRITE;
    localparam ctrl_t M_MEMTOREG = ctrl_t'(1) << CB_MEMTOREG;
    localparam ctrl_t M_PCTOREG  = ctrl_t'(1) << CB_PCTOREG;
    localparam ctrl_t M_BRZ      = ctrl_t'(1) << CB_BRZ;
    localparam ctrl_t M_BRN      = ctrl_t'(1) << CB_BRN;
    localparam ctrl_t M_JUMP     = ctrl_t'(1) << CB_JUMP;
    localparam ctrl_t M_JUMPMEM  = ctrl_t'(1) << CB_JUMPMEM;

    localparam ctrl_t NOP_CTRL = ctrl_t'(ALU_NOP) << CB_ALUOP_LSB;

    function automatic ctrl_t alu_word(input logic [2:0] alu);
        return ctrl_t'(alu) << CB_ALUOP_LSB;
    endfunction

    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d.illegal = 1'b0;
        d.ctrl    = NOP_CTRL;
        case (op)
            OP_NOP:         d.ctrl = NOP_CTRL;
            OP_SVPC:        d.ctrl = alu_word(ALU_ADD) | M_USEIMM | M_REGWRITE | M_PCTOREG;
            OP_LD:          d.ctrl = alu_word(ALU_ADD) | M_MEMREAD | M_REGWRITE | M_MEMTOREG;
            OP_ST:          d.ctrl = alu_word(ALU_ADD) | M_MEMWRITE;
            OP_ADD:         d.ctrl = alu_word(ALU_ADD) | M_REGWRITE;
            OP_INC:         d.ctrl = alu_word(ALU_INC) | M_REGWRITE;
            OP_NEG:         d.ctrl = alu_word(ALU_NEG) | M_REGWRITE;
            OP_SUB, OP_MIN: d.ctrl = alu_word(ALU_SUB) | M_REGWRITE;
            OP_J:           d.ctrl = alu_word(ALU_PASSA) | M_JUMP;
            OP_JM:          d.ctrl = alu_word(ALU_PASSA) | M_MEMREAD | M_JUMPMEM;
            OP_BRZ:         d.ctrl = alu_word(ALU_PASSA) | M_BRZ;
            OP_BRN:         d.ctrl = alu_word(ALU_PASSA) | M_BRN;
            default: begin
                d.ctrl    = NOP_CTRL;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational ID-stage opcode to control-word decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 4,
    parameter int CW  = 13
) (
    input  logic [OPW-1:0] i_opcode,
    output logic [CW-1:0]  o_ctrl,
    output logic           o_illegal
);

    logic w_hi_bits;
    dec_t w_dec;

    // Opcode bits above the 4-bit operation field must all be zero.
    generate
        if (OPW > 4) begin : g_wide
            assign w_hi_bits = |i_opcode[OPW-1:4];
        end else begin : g_narrow
            assign w_hi_bits = 1'b0;
        end
    endgenerate

    assign w_dec     = decode(i_opcode[3:0]);
    assign o_ctrl    = w_hi_bits ? NOP_CTRL : w_dec.ctrl;
    assign o_illegal = w_hi_bits | w_dec.illegal;

endmodule

`default_nettype wire

// File: rtl/ctrl_pipe_unit.sv
// ============================================================================
// Module   : ctrl_pipe_unit
// Brief    : Pipelined control unit: ID decode, EX/MEM/WB control registers,
//            load-use stall and redirect flush. CTRL_PERF_EN adds counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int RAW  = 6,
    parameter int CW   = 13,
    parameter int CNTW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [OPW-1:0] id_opcode,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic [RAW-1:0] id_rd,
    input  logic           ex_redirect,
    output logic           stall_o,
    output logic           flush_o,
    output logic [CW-1:0]  ex_ctrl,
    output logic [CW-1:0]  mem_ctrl,
    output logic [CW-1:0]  wb_ctrl,
    output logic [RAW-1:0] ex_rd,
    output logic [RAW-1:0] mem_rd,
    output logic [RAW-1:0] wb_rd,
    output logic           ex_valid,
    output logic           mem_valid,
    output logic           wb_valid,
    output logic           illegal_o
`ifdef CTRL_PERF_EN
    ,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
`endif
);

    generate
        if (CW != CTRL_W || OPW < 4 || CNTW < 1) begin : g_bad_param
            $error("ctrl_pipe_unit: unsupported parameter set");
        end
    endgenerate

    logic [CW-1:0]  w_dec_ctrl;
    logic           w_dec_illegal;
    logic           w_load_use;
    logic           w_bubble;

    logic [CW-1:0]  r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
    logic [RAW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic           r_ex_valid, r_mem_valid, r_wb_valid;
    logic           r_ex_illegal;

    ctrl_decode #(
        .OPW (OPW),
        .CW  (CW)
    ) u_decode (
        .i_opcode  (id_opcode),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    // A load in EX whose destination feeds either ID source; r0 is never a producer.
    assign w_load_use = r_ex_valid && r_ex_ctrl[CB_MEMREAD] && id_valid &&
                        (r_ex_rd != '0) && ((r_ex_rd == id_rs) || (r_ex_rd == id_rt));

    assign flush_o  = rst_n & ex_redirect;
    assign stall_o  = rst_n & w_load_use & ~ex_redirect;
    assign w_bubble = ex_redirect | w_load_use | ~id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_ctrl    <= NOP_CTRL;
            r_mem_ctrl   <= NOP_CTRL;
            r_wb_ctrl    <= NOP_CTRL;
            r_ex_rd      <= '0;
            r_mem_rd     <= '0;
            r_wb_rd      <= '0;
            r_ex_valid   <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_ex_illegal <= 1'b0;
        end else begin
            r_wb_ctrl   <= r_mem_ctrl;
            r_wb_rd     <= r_mem_rd;
            r_wb_valid  <= r_mem_valid;
            r_mem_ctrl  <= r_ex_ctrl;
            r_mem_rd    <= r_ex_rd;
            r_mem_valid <= r_ex_valid;
            if (w_bubble) begin
                r_ex_ctrl    <= NOP_CTRL;
                r_ex_rd      <= '0;
                r_ex_valid   <= 1'b0;
                r_ex_illegal <= 1'b0;
            end else begin
                r_ex_ctrl    <= w_dec_ctrl;
                r_ex_rd      <= id_rd;
                r_ex_valid   <= 1'b1;
                r_ex_illegal <= w_dec_illegal;
            end
        end
    end

    assign ex_ctrl   = r_ex_ctrl;
    assign mem_ctrl  = r_mem_ctrl;
    assign wb_ctrl   = r_wb_ctrl;
    assign ex_rd     = r_ex_rd;
    assign mem_rd    = r_mem_rd;
    assign wb_rd     = r_wb_rd;
    assign ex_valid  = r_ex_valid;
    assign mem_valid = r_mem_valid;
    assign wb_valid  = r_wb_valid;
    assign illegal_o = r_ex_illegal;

`ifdef CTRL_PERF_EN
    logic [CNTW-1:0] r_stall_cnt, r_flush_cnt;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_o && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
            if (flush_o && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNTW'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    // Counter ports and registers are absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe_unit.sv
// ============================================================================
// Module   : tb_ctrl_pipe_unit
// Brief    : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ctrl_pipe_unit;

    localparam int OPW  = 4;
    localparam int RAW  = 6;
    localparam int CW   = 13;
    localparam int CNTW = 16;
    localparam logic [12:0] NOPW = 13'h0800;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           id_valid = 1'b0;
    logic [OPW-1:0] id_opcode = '0;
    logic [RAW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic           ex_redirect = 1'b0;
    logic           hi5 = 1'b0;
    logic [OPW:0]   id_opcode5;

    logic           stall_o, flush_o, ex_valid, mem_valid, wb_valid, illegal_o;
    logic [CW-1:0]  ex_ctrl, mem_ctrl, wb_ctrl;
    logic [RAW-1:0] ex_rd, mem_rd, wb_rd;
    logic           stall_5, flush_5, ex_valid_5, mem_valid_5, wb_valid_5, illegal_5;
    logic [CW-1:0]  ex_ctrl_5, mem_ctrl_5, wb_ctrl_5;
    logic [RAW-1:0] ex_rd_5, mem_rd_5, wb_rd_5;
`ifdef CTRL_PERF_EN
    logic [CNTW-1:0] stall_cnt, flush_cnt, stall_cnt_5, flush_cnt_5;
`endif

    assign id_opcode5 = {hi5, id_opcode};

    always #5 clk = ~clk;

    ctrl_pipe_unit #(.OPW(OPW), .RAW(RAW), .CW(CW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall_o(stall_o), .flush_o(flush_o), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
        .wb_ctrl(wb_ctrl), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .illegal_o(illegal_o)
`ifdef CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    ctrl_pipe_unit #(.OPW(OPW+1), .RAW(RAW), .CW(CW), .CNTW(CNTW)) dut5 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode5),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall_o(stall_5), .flush_o(flush_5), .ex_ctrl(ex_ctrl_5), .mem_ctrl(mem_ctrl_5),
        .wb_ctrl(wb_ctrl_5), .ex_rd(ex_rd_5), .mem_rd(mem_rd_5), .wb_rd(wb_rd_5),
        .ex_valid(ex_valid_5), .mem_valid(mem_valid_5), .wb_valid(wb_valid_5),
        .illegal_o(illegal_5)
`ifdef CTRL_PERF_EN
        , .stall_cnt(stall_cnt_5), .flush_cnt(flush_cnt_5)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: three pipeline slots [0]=EX [1]=MEM [2]=WB.
    logic [12:0]    ref_ctrl [3];
    logic [RAW-1:0] ref_rd   [3];
    logic           ref_v    [3];
    logic           ref_ill;
    int             ref_sc, ref_fc;

    function automatic logic [13:0] ref_dec(input logic [3:0] op);
        logic [13:0] t [16];
        t = '{14'h0800, 14'h1440, 14'h2800, 14'h0080, 14'h0040, 14'h0440, 14'h1840, 14'h1440,
              14'h1C02, 14'h1C08, 14'h1D01, 14'h1C04, 14'h2800, 14'h2800, 14'h0160, 14'h0250};
        return t[op];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ref_ctrl[k] = NOPW;
            ref_rd[k]   = '0;
            ref_v[k]    = 1'b0;
        end
        ref_ill = 1'b0;
        ref_sc  = 0;
        ref_fc  = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_valid = 1'b0;
        ex_redirect = 1'b0;
        hi5 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // One clock with full model comparison; inputs must already be applied.
    task automatic cycle();
        logic hz, st, fl;
        logic [13:0] d;
        @(negedge clk);
        hz = ref_v[0] && ref_ctrl[0][8] && id_valid && (ref_rd[0] != '0) &&
             ((ref_rd[0] == id_rs) || (ref_rd[0] == id_rt));
        fl = ex_redirect;
        st = hz && !ex_redirect;
        chk("stall_o", stall_o, st);
        chk("flush_o", flush_o, fl);
        chk("ex_ctrl", ex_ctrl, ref_ctrl[0]);
        chk("mem_ctrl", mem_ctrl, ref_ctrl[1]);
        chk("wb_ctrl", wb_ctrl, ref_ctrl[2]);
        chk("ex_valid", ex_valid, ref_v[0]);
        chk("mem_valid", mem_valid, ref_v[1]);
        chk("wb_valid", wb_valid, ref_v[2]);
        chk("illegal_o", illegal_o, ref_ill);
        if (ref_v[0]) chk("ex_rd", ex_rd, ref_rd[0]);
        if (ref_v[1]) chk("mem_rd", mem_rd, ref_rd[1]);
        if (ref_v[2]) chk("wb_rd", wb_rd, ref_rd[2]);
        @(posedge clk);
        ref_sc += int'(st);
        ref_fc += int'(fl);
        for (int k = 2; k > 0; k--) begin
            ref_ctrl[k] = ref_ctrl[k-1];
            ref_rd[k]   = ref_rd[k-1];
            ref_v[k]    = ref_v[k-1];
        end
        if (fl || st || !id_valid) begin
            ref_ctrl[0] = NOPW;
            ref_rd[0]   = '0;
            ref_v[0]    = 1'b0;
            ref_ill     = 1'b0;
        end else begin
            d = ref_dec(id_opcode);
            ref_ctrl[0] = d[12:0];
            ref_rd[0]   = id_rd;
            ref_v[0]    = 1'b1;
            ref_ill     = d[13];
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [RAW-1:0] rs,
                         input logic [RAW-1:0] rt, input logic [RAW-1:0] rd, input logic rdr);
        id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_redirect = rdr;
    endtask

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [5:0]  rs, rt, rd;
        logic        redir;
        logic        e_stall, e_flush;
        logic [12:0] e_ctrl;
        logic        e_v, e_ill;
    } vec_t;

    localparam int NV = 21;
    vec_t tv [NV];

    initial begin
        // v op rs rt rd redir | stall flush next_ex_ctrl ex_valid illegal
        tv[0]  = '{1'b0, 4'h0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 13'h0800, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 4'h4, 6'd1, 6'd2, 6'd5, 1'b0, 1'b0, 1'b0, 13'h0040, 1'b1, 1'b0};
        tv[2]  = '{1'b1, 4'hE, 6'd1, 6'd1, 6'd3, 1'b0, 1'b0, 1'b0, 13'h0160, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 4'h7, 6'd3, 6'd4, 6'd6, 1'b0, 1'b1, 1'b0, 13'h0800, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 4'h7, 6'd3, 6'd4, 6'd6, 1'b0, 1'b0, 1'b0, 13'h1440, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 4'hE, 6'd2, 6'd2, 6'd0, 1'b0, 1'b0, 1'b0, 13'h0160, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 4'h4, 6'd0, 6'd0, 6'd2, 1'b0, 1'b0, 1'b0, 13'h0040, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 4'hE, 6'd1, 6'd1, 6'd7, 1'b0, 1'b0, 1'b0, 13'h0160, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 4'h4, 6'd7, 6'd1, 6'd2, 1'b1, 1'b0, 1'b1, 13'h0800, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 4'h2, 6'd1, 6'd1, 6'd3, 1'b0, 1'b0, 1'b0, 13'h0800, 1'b1, 1'b1};
        tv[10] = '{1'b1, 4'h8, 6'd1, 6'd1, 6'd0, 1'b0, 1'b0, 1'b0, 13'h1C02, 1'b1, 1'b0};
        tv[11] = '{1'b1, 4'hE, 6'd1, 6'd1, 6'd9, 1'b0, 1'b0, 1'b0, 13'h0160, 1'b1, 1'b0};
        tv[12] = '{1'b1, 4'h3, 6'd1, 6'd9, 6'd0, 1'b0, 1'b1, 1'b0, 13'h0800, 1'b0, 1'b0};
        tv[13] = '{1'b1, 4'h3, 6'd1, 6'd9, 6'd0, 1'b0, 1'b0, 1'b0, 13'h0080, 1'b1, 1'b0};
        tv[14] = '{1'b1, 4'hE, 6'd1, 6'd1, 6'd4, 1'b0, 1'b0, 1'b0, 13'h0160, 1'b1, 1'b0};
        tv[15] = '{1'b1, 4'hE, 6'd4, 6'd1, 6'd4, 1'b0, 1'b1, 1'b0, 13'h0800, 1'b0, 1'b0};
        tv[16] = '{1'b1, 4'hE, 6'd4, 6'd1, 6'd4, 1'b0, 1'b0, 1'b0, 13'h0160, 1'b1, 1'b0};
        tv[17] = '{1'b1, 4'h4, 6'd4, 6'd2, 6'd8, 1'b0, 1'b1, 1'b0, 13'h0800, 1'b0, 1'b0};
        tv[18] = '{1'b1, 4'h4, 6'd4, 6'd2, 6'd8, 1'b0, 1'b0, 1'b0, 13'h0040, 1'b1, 1'b0};
        tv[19] = '{1'b1, 4'hE, 6'd1, 6'd1, 6'd5, 1'b0, 1'b0, 1'b0, 13'h0160, 1'b1, 1'b0};
        tv[20] = '{1'b0, 4'h4, 6'd5, 6'd5, 6'd1, 1'b0, 1'b0, 1'b0, 13'h0800, 1'b0, 1'b0};

        model_reset();
        do_reset();

        // Reset state with idle ID for three cycles.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ex_ctrl", ex_ctrl, NOPW);
            chk("rst_mem_ctrl", mem_ctrl, NOPW);
            chk("rst_wb_ctrl", wb_ctrl, NOPW);
            chk("rst_valids", {ex_valid, mem_valid, wb_valid}, 3'b000);
            chk("rst_stall_flush", {stall_o, flush_o}, 2'b00);
            chk("rst_illegal", illegal_o, 1'b0);
        end
        @(posedge clk); #1;

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            drive(tv[i].v, tv[i].op, tv[i].rs, tv[i].rt, tv[i].rd, tv[i].redir);
            @(negedge clk);
            chk($sformatf("tv%0d_stall", i), stall_o, tv[i].e_stall);
            chk($sformatf("tv%0d_flush", i), flush_o, tv[i].e_flush);
            @(posedge clk); #1;
            chk($sformatf("tv%0d_ex_ctrl", i), ex_ctrl, tv[i].e_ctrl);
            chk($sformatf("tv%0d_ex_valid", i), ex_valid, tv[i].e_v);
            chk($sformatf("tv%0d_illegal", i), illegal_o, tv[i].e_ill);
            if (tv[i].e_v) chk($sformatf("tv%0d_ex_rd", i), ex_rd, tv[i].rd);
        end

        // Latency: ADD rd=5 reaches EX, MEM, WB on successive edges.
        do_reset();
        drive(1'b1, 4'h4, 6'd1, 6'd2, 6'd5, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0, 1'b0);
        chk("lat_ex_ctrl", ex_ctrl, 13'h0040);
        chk("lat_ex_rd", ex_rd, 6'd5);
        @(posedge clk); #1;
        chk("lat_mem_ctrl", mem_ctrl, 13'h0040);
        chk("lat_mem_rd", mem_rd, 6'd5);
        chk("lat_ex_idle", ex_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_wb_ctrl", wb_ctrl, 13'h0040);
        chk("lat_wb_rd", wb_rd, 6'd5);
        chk("lat_wb_valid", wb_valid, 1'b1);

        // Upper opcode bit makes the wide instance see an illegal opcode.
        hi5 = 1'b1;
        drive(1'b1, 4'h4, 6'd1, 6'd2, 6'd2, 1'b0);
        @(posedge clk); #1;
        chk("op5_illegal_ctrl", ex_ctrl_5, NOPW);
        chk("op5_illegal_flag", illegal_5, 1'b1);
        chk("op5_illegal_valid", ex_valid_5, 1'b1);
        chk("op4_add_ctrl", ex_ctrl, 13'h0040);
        chk("op4_add_flag", illegal_o, 1'b0);
        hi5 = 1'b0;
        @(posedge clk); #1;
        chk("op5_legal_ctrl", ex_ctrl_5, 13'h0040);
        chk("op5_legal_flag", illegal_5, 1'b0);

        // Asynchronous reset asserted in the middle of a stall cycle.
        drive(1'b1, 4'hE, 6'd1, 6'd1, 6'd3, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 4'h7, 6'd3, 6'd4, 6'd6, 1'b0);
        @(negedge clk);
        chk("ar_pre_stall", stall_o, 1'b1);
        #2 rst_n = 1'b0;
        ex_redirect = 1'b1;
        #1;
        chk("ar_stall", stall_o, 1'b0);
        chk("ar_flush", flush_o, 1'b0);
        chk("ar_ex_ctrl", ex_ctrl, NOPW);
        chk("ar_valids", {ex_valid, mem_valid, wb_valid}, 3'b000);
        chk("ar_ex_rd", ex_rd, 6'd0);
        @(posedge clk); #1;
        do_reset();

        // Two stalls and one flush, checked by model and by counters.
        drive(1'b1, 4'hE, 6'd1, 6'd1, 6'd3, 1'b0); cycle();
        drive(1'b1, 4'h7, 6'd3, 6'd0, 6'd6, 1'b0); cycle();
        cycle();
        drive(1'b1, 4'hE, 6'd1, 6'd1, 6'd3, 1'b0); cycle();
        drive(1'b1, 4'h4, 6'd2, 6'd3, 6'd6, 1'b0); cycle();
        cycle();
        drive(1'b1, 4'h4, 6'd1, 6'd1, 6'd1, 1'b1); cycle();
        drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0, 1'b0); cycle();
`ifdef CTRL_PERF_EN
        chk("cnt_stall", stall_cnt, 16'd2);
        chk("cnt_flush", flush_cnt, 16'd1);
`endif

        // Randomized run against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)),
                  6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                  6'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 2) == 0) id_opcode = 4'hE;
            cycle();
        end
        drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0, 1'b0);
        cycle();
`ifdef CTRL_PERF_EN
        chk("rnd_stall_cnt", stall_cnt, ref_sc);
        chk("rnd_flush_cnt", flush_cnt, ref_fc);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
